ttt_auto_player: RTL and testbench
==================================

// Module: ttt_auto_player
// PURPOSE
//   Automatic opponent for tic_tac_toe: reads the 9 cell LED pairs and the turn/win flags,
//   picks a move, and drives the matching cell button as a clean timed pulse. Sits between
//   the board core (LED outputs) and its button inputs.
//   Used in single-player game_mode in place of the P2 push-buttons.
// PARAMETERS
//   SETTLE_CYCLES  2   cycles to wait after my_turn rises before sampling the board (LED settle)
//   PRESS_CYCLES   4   cycles the chosen button is held high
//   TIMEOUT_CYCLES 64  cycles after release to wait for my_turn to drop before flagging an error
// PORTS
//   clk        in   1   system clock; all state updates on rising edge
//   reset      in   1   asynchronous, active-high reset
//   enable     in   1   from game_mode: 1 = auto player active
//   my_turn    in   1   from p2_turn
//   p1_win     in   1   board core win flag
//   p2_win     in   1   board core win flag
//   grid_full  in   1   board core full flag
//   board      in   18  {a_led,b_led,...,i_led}; a_led = [17:16]. Encoding: 00 empty, 01 P1, 10 P2; 11 treated as occupied
//   press      out  9   one-hot button drive {a,b,...,i}; a = bit 8
//   busy       out  1   high in any state other than IDLE
//   move_idx   out  4   last chosen cell, 0 = a .. 8 = i; 4'hF = none yet
//   move_err   out  1   sticky: turn never handed back after a press (cleared only by reset)
// BEHAVIOUR
//   Reset (async, immediate): state IDLE, press = 0, busy = 0, move_idx = 4'hF, move_err = 0, counters = 0.
//   game_over = p1_win | p2_win | grid_full.
//   FSM: IDLE -> SETTLE -> DECIDE -> PRESS -> RELEASE -> IDLE.
//   IDLE:    go to SETTLE when enable & my_turn & !game_over.
//   SETTLE:  count SETTLE_CYCLES, then go to DECIDE.
//   DECIDE:  1 cycle; register board and compute the move.
//            If no cell is empty, go to IDLE with press = 0.
//            Otherwise register move_idx and go to PRESS.
//   PRESS:   press = one-hot(move_idx) for exactly PRESS_CYCLES cycles, registered output with no glitches, then RELEASE.
//   RELEASE: press = 0. Go to IDLE when my_turn = 0.
//            If TIMEOUT_CYCLES elapse first, set move_err and go to IDLE.
//   Latency: my_turn rise -> first press cycle = SETTLE_CYCLES + 2 clocks.
//   Abort: if !enable or game_over in any non-IDLE state, next edge forces press = 0 and goes to IDLE;
//          move_idx keeps its last value.
//   Re-arm: IDLE will not accept a new turn until my_turn has been seen low. This prevents a
//           double move if the core ignores a press and leaves my_turn high; that case ends in move_err.
//   Move priority, first match wins:
//     1) win: a line with two P2 cells and one empty -> take the empty cell
//     2) block: the same rule with P1 cells
//     3) centre e
//     4) corners in order a, c, g, i
//     5) sides in order b, d, f, h
//   Line scan order for 1) and 2): rows abc, def, ghi; columns adg, beh, cfi; diagonals aei, ceg.
//   The first qualifying line in this order is used.
//   Press only ever targets an empty cell; occupied-cell presses must never be issued.
// STRUCTURE
//   ttt_defs.vh (shared header): cell codes EMPTY/P1/P2, cell index constants A..I, 8-entry line table, FSM state codes.
//   Sub-module ttt_move_picker: purely combinational; board[17:0] -> {valid, idx[3:0]} implementing the priority rules.
//   Top level holds the FSM, the shared down-counter (settle/press/timeout) and the output registers.
// TESTING
//   1) Reset mid-PRESS (at PRESS cycle 2) -> press = 0 immediately (async), busy = 0, move_idx = F, move_err = 0.
//   2) Empty board, enable = 1, my_turn rises -> after 4 clks press = 9'b000010000 (e) for 4 clks; move_idx = 4.
//   3) Board a = P2, b = P2, d = P1, e = P1, all others empty -> press c (9'b001000000);
//      the win is chosen over the block at f.
//   4) Board a = P1, e = P1, c = P2, all others empty -> press i (block on the diagonal), move_idx = 8.
//   5) my_turn held high after the press for 64 clks -> move_err = 1, IDLE, no second press while my_turn stays high.
//   6) p1_win rises during SETTLE -> no press is ever issued, busy falls the next clk.
//      Also: enable = 0 with my_turn = 1 -> press stays 0.

Source files
------------

// File: rtl/ttt_auto_player_pkg.sv
// Shared definitions for the tic-tac-toe auto player: cell codes, cell indices,
// the winning-line table, the fallback move order and FSM state codes.
package ttt_auto_player_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;

  localparam logic [3:0] IDX_A    = 4'd0;
  localparam logic [3:0] IDX_B    = 4'd1;
  localparam logic [3:0] IDX_C    = 4'd2;
  localparam logic [3:0] IDX_D    = 4'd3;
  localparam logic [3:0] IDX_E    = 4'd4;
  localparam logic [3:0] IDX_F    = 4'd5;
  localparam logic [3:0] IDX_G    = 4'd6;
  localparam logic [3:0] IDX_H    = 4'd7;
  localparam logic [3:0] IDX_I    = 4'd8;
  localparam logic [3:0] IDX_NONE = 4'hF;

  // Each entry packs three cell indices {first, second, third}; order is the scan priority.
  localparam logic [11:0] LINES [8] = '{
    {IDX_A, IDX_B, IDX_C}, {IDX_D, IDX_E, IDX_F}, {IDX_G, IDX_H, IDX_I},
    {IDX_A, IDX_D, IDX_G}, {IDX_B, IDX_E, IDX_H}, {IDX_C, IDX_F, IDX_I},
    {IDX_A, IDX_E, IDX_I}, {IDX_C, IDX_E, IDX_G}
  };

  // Centre, then corners, then sides.
  localparam logic [3:0] FALLBACK [9] = '{
    IDX_E, IDX_A, IDX_C, IDX_G, IDX_I, IDX_B, IDX_D, IDX_F, IDX_H
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_DECIDE,
    ST_PRESS,
    ST_RELEASE
  } state_t;

  // Cell a occupies the top two bits of the board vector.
  function automatic logic [1:0] cell_at(input logic [17:0] b, input int idx);
    return b[17-2*idx -: 2];
  endfunction

  // Button vector has cell a on bit 8.
  function automatic logic [8:0] cell_onehot(input logic [3:0] idx);
    logic [8:0] r;
    r = '0;
    for (int k = 0; k < 9; k++) begin
      r[8-k] = (idx == 4'(k));
    end
    return r;
  endfunction

endpackage

// File: rtl/ttt_move_picker.sv
// Combinational move selection: win, then block, then centre, corners, sides.
// Only empty cells are ever returned; valid = 0 when the board is full.
module ttt_move_picker
  import ttt_auto_player_pkg::*;
(
  input  logic [17:0] board,
  output logic        valid,
  output logic [3:0]  idx
);

  logic [7:0] p2_two;
  logic [7:0] p1_two;
  logic [3:0] line_hole [8];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_line
      localparam logic [3:0] C0 = LINES[gi][11:8];
      localparam logic [3:0] C1 = LINES[gi][7:4];
      localparam logic [3:0] C2 = LINES[gi][3:0];
      logic [1:0] v0, v1, v2;
      logic [1:0] n_empty, n_p1, n_p2;
      assign v0 = cell_at(board, int'(C0));
      assign v1 = cell_at(board, int'(C1));
      assign v2 = cell_at(board, int'(C2));
      assign n_empty = 2'(v0 == CELL_EMPTY) + 2'(v1 == CELL_EMPTY) + 2'(v2 == CELL_EMPTY);
      assign n_p1    = 2'(v0 == CELL_P1) + 2'(v1 == CELL_P1) + 2'(v2 == CELL_P1);
      assign n_p2    = 2'(v0 == CELL_P2) + 2'(v1 == CELL_P2) + 2'(v2 == CELL_P2);
      assign p2_two[gi] = (n_empty == 2'd1) && (n_p2 == 2'd2);
      assign p1_two[gi] = (n_empty == 2'd1) && (n_p1 == 2'd2);
      assign line_hole[gi] = (v0 == CELL_EMPTY) ? C0 : ((v1 == CELL_EMPTY) ? C1 : C2);
    end
  endgenerate

  always_comb begin
    valid = 1'b0;
    idx   = IDX_NONE;
    for (int l = 0; l < 8; l++) begin
      if (!valid && p2_two[l]) begin
        valid = 1'b1;
        idx   = line_hole[l];
      end
    end
    for (int l = 0; l < 8; l++) begin
      if (!valid && p1_two[l]) begin
        valid = 1'b1;
        idx   = line_hole[l];
      end
    end
    for (int k = 0; k < 9; k++) begin
      if (!valid && (cell_at(board, int'(FALLBACK[k])) == CELL_EMPTY)) begin
        valid = 1'b1;
        idx   = FALLBACK[k];
      end
    end
  end

endmodule

// File: rtl/ttt_auto_player.sv
// Automatic second player: waits for its turn, lets the LEDs settle, picks a move
// and drives the chosen cell button as a registered pulse of fixed length.
module ttt_auto_player
  import ttt_auto_player_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 2,
  parameter int PRESS_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        my_turn,
  input  logic        p1_win,
  input  logic        p2_win,
  input  logic        grid_full,
  input  logic [17:0] board,
  output logic [8:0]  press,
  output logic        busy,
  output logic [3:0]  move_idx,
  output logic        move_err
);

  localparam int CNT_W = 16;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [8:0]       press_reg, press_next;
  logic [3:0]       move_idx_reg, move_idx_next;
  logic             move_err_reg, move_err_next;
  logic             armed_reg, armed_next;

  logic       game_over;
  logic       pick_valid;
  logic [3:0] pick_idx;

  ttt_move_picker u_picker (
    .board (board),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign game_over = p1_win | p2_win | grid_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      press_reg    <= '0;
      move_idx_reg <= IDX_NONE;
      move_err_reg <= 1'b0;
      armed_reg    <= 1'b1;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      press_reg    <= press_next;
      move_idx_reg <= move_idx_next;
      move_err_reg <= move_err_next;
      armed_reg    <= armed_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    press_next    = press_reg;
    move_idx_next = move_idx_reg;
    move_err_next = move_err_reg;
    // A new turn is accepted only after my_turn has been seen low once.
    armed_next    = armed_reg | ~my_turn;

    if ((state_reg != ST_IDLE) && (!enable || game_over)) begin
      state_next = ST_IDLE;
      press_next = '0;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (enable && my_turn && !game_over && armed_reg) begin
            state_next = ST_SETTLE;
            cnt_next   = CNT_W'(SETTLE_CYCLES - 1);
            armed_next = 1'b0;
          end
        end
        ST_SETTLE: begin
          if (cnt_reg == '0) begin
            state_next = ST_DECIDE;
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
        ST_DECIDE: begin
          if (pick_valid) begin
            move_idx_next = pick_idx;
            press_next    = cell_onehot(pick_idx);
            cnt_next      = CNT_W'(PRESS_CYCLES - 1);
            state_next    = ST_PRESS;
          end else begin
            press_next = '0;
            state_next = ST_IDLE;
          end
        end
        ST_PRESS: begin
          if (cnt_reg == '0) begin
            press_next = '0;
            cnt_next   = CNT_W'(TIMEOUT_CYCLES - 1);
            state_next = ST_RELEASE;
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
        ST_RELEASE: begin
          if (!my_turn) begin
            cnt_next   = '0;
            state_next = ST_IDLE;
          end else if (cnt_reg == '0) begin
            move_err_next = 1'b1;
            state_next    = ST_IDLE;
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
        default: begin
          press_next = '0;
          cnt_next   = '0;
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  assign press    = press_reg;
  assign busy     = (state_reg != ST_IDLE);
  assign move_idx = move_idx_reg;
  assign move_err = move_err_reg;

endmodule

// File: tb/tb_ttt_auto_player.sv
// Directed bench for ttt_auto_player: move choice, pulse timing, timeout, aborts and reset.
module tb_ttt_auto_player;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        my_turn;
  logic        p1_win;
  logic        p2_win;
  logic        grid_full;
  logic [17:0] board;
  logic [8:0]  press;
  logic        busy;
  logic [3:0]  move_idx;
  logic        move_err;

  int total;
  int bad;

  ttt_auto_player dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .my_turn   (my_turn),
    .p1_win    (p1_win),
    .p2_win    (p2_win),
    .grid_full (grid_full),
    .board     (board),
    .press     (press),
    .busy      (busy),
    .move_idx  (move_idx),
    .move_err  (move_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    total++; if (press !== 9'b0)    begin bad++; $display("FAIL reset_press got=%b want=%b", press, 9'b0); end
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (move_idx !== 4'hF) begin bad++; $display("FAIL reset_move_idx got=%h want=f", move_idx); end
    total++; if (move_err !== 1'b0) begin bad++; $display("FAIL reset_move_err got=%b want=0", move_err); end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%b want=0", busy); end
    $display("reset: press=%b busy=%b move_idx=%h move_err=%b", press, busy, move_idx, move_err);
  endtask

  // One full turn: press must appear on clocks 4..7 after my_turn rises.
  task automatic test_move(input string name, input logic [17:0] b,
                           input logic [8:0] exp_press, input logic [3:0] exp_idx);
    logic [8:0] want;
    @(negedge clk);
    board   = b;
    enable  = 1'b1;
    my_turn = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      want = (c >= 4 && c <= 7) ? exp_press : 9'b0;
      total++;
      if (press !== want) begin
        bad++;
        $display("FAIL %s_press_c%0d got=%b want=%b", name, c, press, want);
      end
    end
    total++; if (busy !== 1'b1)       begin bad++; $display("FAIL %s_busy_release got=%b want=1", name, busy); end
    total++; if (move_idx !== exp_idx) begin bad++; $display("FAIL %s_move_idx got=%h want=%h", name, move_idx, exp_idx); end
    @(negedge clk);
    my_turn = 1'b0;
    @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s_busy_after got=%b want=0", name, busy); end
    $display("move %s: press=%b move_idx=%0d", name, exp_press, move_idx);
  endtask

  task automatic test_timeout();
    logic [8:0] want;
    @(negedge clk);
    board   = 18'h0;
    enable  = 1'b1;
    my_turn = 1'b1;
    for (int c = 1; c <= 72; c++) begin
      @(posedge clk);
      #1;
      want = (c >= 4 && c <= 7) ? 9'b000010000 : 9'b0;
      total++;
      if (press !== want) begin bad++; $display("FAIL timeout_press_c%0d got=%b want=%b", c, press, want); end
      if (c == 71) begin
        total++; if (move_err !== 1'b0) begin bad++; $display("FAIL timeout_err_early got=%b want=0", move_err); end
        total++; if (busy !== 1'b1)     begin bad++; $display("FAIL timeout_busy_early got=%b want=1", busy); end
      end
    end
    total++; if (move_err !== 1'b1) begin bad++; $display("FAIL timeout_err got=%b want=1", move_err); end
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL timeout_busy got=%b want=0", busy); end
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      total++;
      if (press !== 9'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL timeout_rearm_c%0d press=%b busy=%b want press=0 busy=0", c, press, busy);
      end
    end
    total++; if (move_err !== 1'b1) begin bad++; $display("FAIL timeout_err_sticky got=%b want=1", move_err); end
    @(negedge clk);
    my_turn = 1'b0;
    $display("timeout: move_err=%b busy=%b", move_err, busy);
  endtask

  task automatic test_reset_mid_press();
    @(negedge clk);
    board   = 18'h0;
    enable  = 1'b1;
    my_turn = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    total++; if (press !== 9'b000010000) begin bad++; $display("FAIL midreset_pre_press got=%b want=%b", press, 9'b000010000); end
    #1;
    reset = 1'b1;
    #1;
    total++; if (press !== 9'b0)    begin bad++; $display("FAIL midreset_press got=%b want=0", press); end
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL midreset_busy got=%b want=0", busy); end
    total++; if (move_idx !== 4'hF) begin bad++; $display("FAIL midreset_move_idx got=%h want=f", move_idx); end
    total++; if (move_err !== 1'b0) begin bad++; $display("FAIL midreset_move_err got=%b want=0", move_err); end
    @(negedge clk);
    my_turn = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    $display("reset mid press: press=%b busy=%b move_idx=%h move_err=%b", press, busy, move_idx, move_err);
  endtask

  task automatic test_abort();
    @(negedge clk);
    board   = 18'h0;
    enable  = 1'b1;
    my_turn = 1'b1;
    @(posedge clk);
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_busy_settle got=%b want=1", busy); end
    @(negedge clk);
    p1_win = 1'b1;
    @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy_fall got=%b want=0", busy); end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      total++;
      if (press !== 9'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL abort_hold_c%0d press=%b busy=%b want press=0 busy=0", c, press, busy);
      end
    end
    total++; if (move_idx !== 4'hF) begin bad++; $display("FAIL abort_move_idx got=%h want=f", move_idx); end
    @(negedge clk);
    my_turn = 1'b0;
    p1_win  = 1'b0;
    $display("abort: press=%b busy=%b move_idx=%h", press, busy, move_idx);
  endtask

  task automatic test_disable();
    @(negedge clk);
    board   = 18'h0;
    enable  = 1'b0;
    my_turn = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      total++;
      if (press !== 9'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL disable_c%0d press=%b busy=%b want press=0 busy=0", c, press, busy);
      end
    end
    @(negedge clk);
    my_turn = 1'b0;
    enable  = 1'b1;
    $display("disable: press=%b busy=%b", press, busy);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    enable    = 1'b0;
    my_turn   = 1'b0;
    p1_win    = 1'b0;
    p2_win    = 1'b0;
    grid_full = 1'b0;
    board     = 18'h0;
    #12;
    test_reset();
    test_move("centre", 18'h0, 9'b000010000, 4'd4);
    test_move("win",    18'b10_10_00_01_01_00_00_00_00, 9'b001000000, 4'd2);
    test_move("block",  18'b01_00_10_00_01_00_00_00_00, 9'b000000001, 4'd8);
    test_timeout();
    test_reset_mid_press();
    test_abort();
    test_disable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
